// File: rtl/motor_cmd_sequencer.sv
// Switch-driven motor command sequencer: synchronises and debounces the switches,
// slews the PWM duty at a fixed rate and inserts ramp-down/dead time on direction changes.
module motor_cmd_sequencer #(
   parameter int RAMP_DIV      = 1000000,
   parameter int DEAD_CYCLES   = 5000000,
   parameter int STABLE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sw,
   input  logic       estop,
   output logic [5:0] duty,
   output logic [3:0] tank_dir,
   output logic       busy
);

   localparam int PW = $clog2(RAMP_DIV);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);
   localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {ST_DEAD, ST_RUN, ST_RAMP_DOWN} state_t;

   logic [7:0]    r_sw_s1, r_sw_s2, r_sw_prev, r_sw_f;
   logic [SW-1:0] r_stab_cnt;
   logic          r_es_s1, r_es_s2;
   logic [PW-1:0] r_presc;
   state_t        r_state;
   logic [DW-1:0] r_dead_cnt;
   logic [5:0]    r_duty;
   logic [1:0]    r_active_dir;
   logic [3:0]    r_tank_dir;
   logic          r_busy;

   state_t        w_state_next;
   logic [DW-1:0] w_dead_next;
   logic [5:0]    w_duty_next;
   logic [1:0]    w_dir_next;
   logic [3:0]    w_tank_next;
   logic          w_busy_next;
   logic          w_tick;
   logic          w_estop;
   logic [1:0]    w_f_dir;
   logic [5:0]    w_f_speed;

   function automatic logic [3:0] map_dir(input logic [1:0] d);
      case (d)
         2'b00:   map_dir = 4'b1001;
         2'b01:   map_dir = 4'b0110;
         2'b10:   map_dir = 4'b1010;
         default: map_dir = 4'b0101;
      endcase
   endfunction

   assign w_tick    = (r_presc == PRESC_LAST);
   assign w_estop   = r_es_s2;
   assign w_f_dir   = r_sw_f[7:6];
   assign w_f_speed = r_sw_f[5:0];

   // Input conditioning and the free-running ramp prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1    <= '0;
         r_sw_s2    <= '0;
         r_sw_prev  <= '0;
         r_sw_f     <= '0;
         r_stab_cnt <= '0;
         r_es_s1    <= 1'b0;
         r_es_s2    <= 1'b0;
         r_presc    <= '0;
      end else begin
         r_sw_s1   <= sw;
         r_sw_s2   <= r_sw_s1;
         r_sw_prev <= r_sw_s2;
         // Counter saturates once the value is accepted; re-copying the same value is harmless.
         if (r_sw_s2 != r_sw_prev) begin
            r_stab_cnt <= '0;
         end else if (r_stab_cnt == STAB_LAST) begin
            r_sw_f <= r_sw_s2;
         end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
         end
         r_es_s1 <= estop;
         r_es_s2 <= r_es_s1;
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_DEAD;
         r_dead_cnt   <= DEAD_LOAD;
         r_duty       <= '0;
         r_active_dir <= '0;
         r_tank_dir   <= 4'b0000;
         r_busy       <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_dead_cnt   <= w_dead_next;
         r_duty       <= w_duty_next;
         r_active_dir <= w_dir_next;
         r_tank_dir   <= w_tank_next;
         r_busy       <= w_busy_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dead_next  = r_dead_cnt;
      w_duty_next  = r_duty;
      w_dir_next   = r_active_dir;
      if (w_estop) begin
         w_state_next = ST_DEAD;
         w_dead_next  = DEAD_LOAD;
         w_duty_next  = '0;
      end else begin
         case (r_state)
            ST_DEAD: begin
               w_duty_next = '0;
               // The decrement to zero coincides with leaving DEAD, giving exactly DEAD_CYCLES clocks off.
               if (r_dead_cnt <= DW'(1)) begin
                  w_state_next = ST_RUN;
                  w_dir_next   = w_f_dir;
                  w_dead_next  = '0;
               end else begin
                  w_dead_next = r_dead_cnt - 1'b1;
               end
            end
            ST_RUN: begin
               if (w_f_dir != r_active_dir) begin
                  w_state_next = ST_RAMP_DOWN;
               end else if (w_tick) begin
                  if (r_duty < w_f_speed) begin
                     w_duty_next = r_duty + 1'b1;
                  end else if (r_duty > w_f_speed) begin
                     w_duty_next = r_duty - 1'b1;
                  end
               end
            end
            ST_RAMP_DOWN: begin
               if (r_duty == '0) begin
                  w_state_next = ST_DEAD;
                  w_dead_next  = DEAD_LOAD;
               end else if (w_f_dir == r_active_dir) begin
                  w_state_next = ST_RUN;
               end else if (w_tick) begin
                  w_duty_next = r_duty - 1'b1;
               end
            end
            default: begin
               w_state_next = ST_DEAD;
               w_dead_next  = DEAD_LOAD;
               w_duty_next  = '0;
            end
         endcase
      end
      w_busy_next = (w_state_next != ST_RUN);
      w_tank_next = (w_state_next == ST_DEAD) ? 4'b0000 : map_dir(w_dir_next);
   end

   assign duty     = r_duty;
   assign tank_dir = r_tank_dir;
   assign busy     = r_busy;

endmodule
